// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
// Shares the MemoryManager write/address port between the CPU dmem port and a
// snapshot engine. A debounced "move done" press makes the engine capture the
// sensor board and write it, then a status word, into memory. The CPU always
// wins the port without added latency; the engine only uses idle cycles.
module board_mem_arbiter #(
  parameter logic [31:0] SENSOR_ADDR  = 32'd4,
  parameter logic [31:0] STATUS_ADDR  = 32'd3,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wEn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_dataIn,
  input  logic [31:0] sensorBoardIn,
  input  logic        buttonPressIn,
  output logic        mem_wEn,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataIn,
  output logic        busy,
  output logic [6:0]  seq,
  output logic        dropped
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_BOARD  = 2'd1,
    WR_STATUS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_snap;
  logic [6:0]       r_seq;
  logic             r_dropped;

  logic             w_press_evt;
  logic             w_eng_slot;
  logic [6:0]       w_seq_inc;
  logic [31:0]      w_eng_addr;
  logic [31:0]      w_eng_data;
  logic             w_drop;
  logic             w_clr;

  assign w_press_evt = r_stable & ~r_stable_d;
  assign w_eng_slot  = (r_state != IDLE) & ~cpu_req;
  assign w_seq_inc   = r_seq + 7'd1;
  assign w_drop      = w_press_evt & (r_state != IDLE);
  assign w_clr       = cpu_req & cpu_wEn & (cpu_addr == STATUS_ADDR);

  assign busy    = (r_state != IDLE);
  assign seq     = r_seq;
  assign dropped = r_dropped;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= buttonPressIn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the stable level follows the synchronised button only after it has differed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= CNT_ZERO;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= CNT_ZERO;
      r_stable <= r_stable;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt    <= CNT_ZERO;
      r_stable <= ~r_stable;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
      r_stable <= r_stable;
    end
  end

  // Delayed stable level used for rising-edge (press event) detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  // Snapshot FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot FSM next state and engine address/data; writes only advance in cycles the CPU leaves free.
  always_comb begin
    w_state_nxt = r_state;
    w_eng_addr  = SENSOR_ADDR;
    w_eng_data  = r_snap;
    case (r_state)
      IDLE: begin
        if (w_press_evt) begin
          w_state_nxt = WR_BOARD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR_BOARD: begin
        w_eng_addr = SENSOR_ADDR;
        w_eng_data = r_snap;
        if (w_eng_slot) begin
          w_state_nxt = WR_STATUS;
        end else begin
          w_state_nxt = WR_BOARD;
        end
      end
      WR_STATUS: begin
        w_eng_addr = STATUS_ADDR;
        w_eng_data = {24'd0, w_seq_inc, 1'b1};
        if (w_eng_slot) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WR_STATUS;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the sensor board in the same cycle the press is accepted; later presses leave it untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snap <= 32'd0;
    end else if ((r_state == IDLE) && w_press_evt) begin
      r_snap <= sensorBoardIn;
    end else begin
      r_snap <= r_snap;
    end
  end

  // Sequence number advances (mod 128) when the status write lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_seq <= 7'd0;
    end else if ((r_state == WR_STATUS) && w_eng_slot) begin
      r_seq <= w_seq_inc;
    end else begin
      r_seq <= r_seq;
    end
  end

  // Sticky drop flag: set by a press while busy, cleared by a CPU store to the status word; set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dropped <= 1'b0;
    end else if (w_drop) begin
      r_dropped <= 1'b1;
    end else if (w_clr) begin
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= r_dropped;
    end
  end

  // Port mux: the CPU path is purely combinational so it sees no added latency.
  always_comb begin
    mem_wEn    = cpu_wEn;
    mem_addr   = cpu_addr;
    mem_dataIn = cpu_dataIn;
    if (w_eng_slot) begin
      mem_wEn    = 1'b1;
      mem_addr   = w_eng_addr;
      mem_dataIn = w_eng_data;
    end else begin
      mem_wEn    = cpu_wEn;
      mem_addr   = cpu_addr;
      mem_dataIn = cpu_dataIn;
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter with a 16-cycle debounce.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_board_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wEn;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_dataIn;
  logic [31:0] sensorBoardIn;
  logic        buttonPressIn;
  logic        mem_wEn;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataIn;
  logic        busy;
  logic [6:0]  seq;
  logic        dropped;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] wq[$];

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  board_mem_arbiter #(
    .SENSOR_ADDR (32'd4),
    .STATUS_ADDR (32'd3),
    .DEBOUNCE_CYC(16),
    .CNT_W       (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_wEn      (cpu_wEn),
    .cpu_addr     (cpu_addr),
    .cpu_dataIn   (cpu_dataIn),
    .sensorBoardIn(sensorBoardIn),
    .buttonPressIn(buttonPressIn),
    .mem_wEn      (mem_wEn),
    .mem_addr     (mem_addr),
    .mem_dataIn   (mem_dataIn),
    .busy         (busy),
    .seq          (seq),
    .dropped      (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log every engine write (port writing while the CPU is not requesting).
  always @(negedge clock) begin
    if (!cpu_req && mem_wEn) wq.push_back({mem_addr, mem_dataIn});
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    else return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  // Raise the button and advance to the cycle in which press_evt is high (18 edges later).
  task automatic press_to_evt();
    cyc();
    buttonPressIn = 1'b1;
    repeat (18) cyc();
  endtask

  task automatic release_btn();
    buttonPressIn = 1'b0;
    repeat (24) cyc();
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_wEn = 1'b0;
    cpu_addr = 32'h0000_0ABC; cpu_dataIn = 32'h5555_AAAA;
    sensorBoardIn = 32'd0; buttonPressIn = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b1, 32'h0000_0010, 32'h1111_2222};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'h0000_0000};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0000, 1'b1, 32'h0000_0003, 32'h0000_0000};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_0001, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_0001};
    tbl[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 1'b1, 32'h0000_0004, 32'h0BAD_CAFE};

    // 1: reset held with button pulses
    repeat (2) cyc();
    buttonPressIn = 1'b1;
    repeat (30) cyc();
    buttonPressIn = 1'b0;
    repeat (2) cyc();
    at_neg();
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_seq", 65'(seq), 65'd0);
    check("rst_dropped", 65'(dropped), 65'd0);
    check("rst_mux", {mem_wEn, mem_addr, mem_dataIn}, {1'b0, 32'h0000_0ABC, 32'h5555_AAAA});
    cyc();
    reset = 1'b1;
    repeat (40) cyc();
    check("rst_no_write", 65'(wq.size()), 65'd0);

    // 2: bouncing button then one clean press
    sensorBoardIn = 32'hA5A5_0F0F;
    wq.delete();
    for (int i = 0; i < 50; i++) begin
      buttonPressIn = ~buttonPressIn;
      repeat (10) cyc();
    end
    check("bounce_no_write", 65'(wq.size()), 65'd0);
    check("bounce_busy", 65'(busy), 65'd0);
    buttonPressIn = 1'b1;
    repeat (40) cyc();
    buttonPressIn = 1'b0;
    repeat (40) cyc();
    check("deb_nwrites", 65'(wq.size()), 65'd2);
    check("deb_board", 65'(wq_at(0)), {1'b0, 32'd4, 32'hA5A5_0F0F});
    check("deb_status", 65'(wq_at(1)), {1'b0, 32'd3, 32'h0000_0003});
    check("deb_seq", 65'(seq), 65'd1);

    // Idle pass-through vectors
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      cyc();
      cpu_req = tbl[i].req; cpu_wEn = tbl[i].wen;
      cpu_addr = tbl[i].addr; cpu_dataIn = tbl[i].data;
      at_neg();
      check($sformatf("tbl%0d", i), {mem_wEn, mem_addr, mem_dataIn},
            {tbl[i].exp_wen, tbl[i].exp_addr, tbl[i].exp_data});
    end
    cyc();
    cpu_req = 1'b0; cpu_wEn = 1'b0;
    check("tbl_no_engine", 65'(wq.size()), 65'd0);
    check("tbl_dropped", 65'(dropped), 65'd0);

    // 3: CPU contention for 50 cycles starting at the press event
    sensorBoardIn = 32'h1234_5678;
    wq.delete();
    press_to_evt();
    for (int i = 0; i < 50; i++) begin
      cpu_req = 1'b1; cpu_wEn = 1'b1;
      cpu_addr = 32'h0000_0100 + 32'(i);
      cpu_dataIn = 32'(i) * 32'h0101_0101;
      if (i == 1) sensorBoardIn = 32'hFFFF_0000;
      at_neg();
      check($sformatf("cont_pass%0d", i), {mem_wEn, mem_addr, mem_dataIn},
            {1'b1, 32'h0000_0100 + 32'(i), 32'(i) * 32'h0101_0101});
      if (i == 1) check("cont_busy", 65'(busy), 65'd1);
      cyc();
    end
    check("cont_no_engine", 65'(wq.size()), 65'd0);
    cpu_req = 1'b0; cpu_wEn = 1'b0;
    at_neg();
    check("cont_board_now", {mem_wEn, mem_addr, mem_dataIn}, {1'b1, 32'd4, 32'h1234_5678});
    cyc();
    at_neg();
    check("cont_status_now", {mem_wEn, mem_addr, mem_dataIn}, {1'b1, 32'd3, 32'h0000_0005});
    cyc();
    release_btn();
    check("cont_nwrites", 65'(wq.size()), 65'd2);
    check("cont_seq", 65'(seq), 65'd2);

    // 4: drops while busy, clear, and simultaneous clear+drop
    sensorBoardIn = 32'hDEAD_BEEF;
    wq.delete();
    cpu_req = 1'b1; cpu_wEn = 1'b0; cpu_addr = 32'd4; cpu_dataIn = 32'd0;
    press_to_evt();
    cyc();
    at_neg();
    check("drop_busy", 65'(busy), 65'd1);
    check("drop_cpu_load", {mem_wEn, mem_addr, mem_dataIn}, {1'b0, 32'd4, 32'd0});
    cyc();
    release_btn();
    sensorBoardIn = 32'hCAFE_F00D;
    press_to_evt();
    at_neg();
    check("drop_before", 65'(dropped), 65'd0);
    cyc();
    at_neg();
    check("drop_set", 65'(dropped), 65'd1);
    cyc();
    release_btn();
    cpu_wEn = 1'b1; cpu_addr = 32'd3;
    at_neg();
    check("drop_hold", 65'(dropped), 65'd1);
    cyc();
    cpu_wEn = 1'b0;
    at_neg();
    check("drop_clear", 65'(dropped), 65'd0);
    cyc();
    press_to_evt();
    cpu_wEn = 1'b1; cpu_addr = 32'd3;
    cyc();
    cpu_wEn = 1'b0;
    at_neg();
    check("drop_set_wins", 65'(dropped), 65'd1);
    cyc();
    cpu_wEn = 1'b1;
    cyc();
    cpu_wEn = 1'b0;
    at_neg();
    check("drop_clear2", 65'(dropped), 65'd0);
    cyc();
    release_btn();
    check("drop_no_engine", 65'(wq.size()), 65'd0);
    cpu_req = 1'b0;
    repeat (5) cyc();
    check("drop_nwrites", 65'(wq.size()), 65'd2);
    check("drop_snap_kept", 65'(wq_at(0)), {1'b0, 32'd4, 32'hDEAD_BEEF});
    check("drop_status", 65'(wq_at(1)), {1'b0, 32'd3, 32'h0000_0007});

    // Reset between tests brings seq back to zero
    reset = 1'b0;
    repeat (3) cyc();
    at_neg();
    check("mid_rst_seq", 65'(seq), 65'd0);
    cyc();
    reset = 1'b1;
    repeat (3) cyc();

    // 5: 128 snapshots wrap seq
    wq.delete();
    for (int k = 0; k < 128; k++) begin
      sensorBoardIn = 32'h1000_0000 + 32'(k);
      press_to_evt();
      repeat (6) cyc();
      buttonPressIn = 1'b0;
      repeat (22) cyc();
    end
    check("wrap_nwrites", 65'(wq.size()), 65'd256);
    for (int k = 0; k < 128; k++) begin
      logic [6:0] kk;
      kk = 7'(k + 1);
      check($sformatf("wrap_board%0d", k), 65'(wq_at(2 * k)), {1'b0, 32'd4, 32'h1000_0000 + 32'(k)});
      check($sformatf("wrap_status%0d", k), 65'(wq_at(2 * k + 1)), {1'b0, 32'd3, 24'd0, kk, 1'b1});
    end
    check("wrap_seq", 65'(seq), 65'd0);

    // 6: reset while in WR_STATUS with the CPU holding the port
    sensorBoardIn = 32'h7777_1111;
    wq.delete();
    press_to_evt();
    cyc();
    cyc();
    check("mid_busy_before", 65'(busy), 65'd1);
    cpu_req = 1'b1; reset = 1'b0; buttonPressIn = 1'b0;
    at_neg();
    check("mid_busy", 65'(busy), 65'd0);
    check("mid_seq", 65'(seq), 65'd0);
    repeat (3) cyc();
    reset = 1'b1; cpu_req = 1'b0;
    repeat (40) cyc();
    check("mid_nwrites", 65'(wq.size()), 65'd1);
    check("mid_board_kept", 65'(wq_at(0)), {1'b0, 32'd4, 32'h7777_1111});
    check("mid_seq_after", 65'(seq), 65'd0);
    check("mid_busy_after", 65'(busy), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
